// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the big-endian, word-wide data memory port.
// One request at a time; byte/half stores are done as read-modify-write.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        mem_write
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  op_q;
    logic        store_q;

    logic        op_illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        req_error;
    logic        store_word;

    // Pick a byte/half lane out of a big-endian word and extend it.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [2:0]  op,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (op[1:0])
            2'b00:   r = op[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = op[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay the store byte/half onto the word read back from memory.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic        half,
        input logic [1:0]  off
    );
        logic [31:0] r;
        r = word;
        if (half) begin
            if (off[1]) r[15:0]  = wdata[15:0];
            else        r[31:16] = wdata[15:0];
        end else begin
            case (off)
                2'd0:    r[31:24] = wdata[7:0];
                2'd1:    r[23:16] = wdata[7:0];
                2'd2:    r[15:8]  = wdata[7:0];
                default: r[7:0]   = wdata[7:0];
            endcase
        end
        return r;
    endfunction

    // Classify the incoming request: legal opcode and natural alignment.
    always_comb begin
        op_illegal = 1'b0;
        misaligned = 1'b0;
        case (req_op)
            3'b000, 3'b001, 3'b011: op_illegal = 1'b0;
            3'b100, 3'b101:         op_illegal = req_store;
            default:                op_illegal = 1'b1;
        endcase
        case (req_op[1:0])
            2'b01:   misaligned = req_address[0];
            2'b11:   misaligned = |req_address[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign out_of_range = req_address > LAST_ADDR;
    assign req_error    = op_illegal | misaligned | out_of_range;
    assign store_word   = req_store & (req_op[1:0] == 2'b11);

    assign req_ready      = (state == IDLE);
    assign mem_address    = {addr_q[31:2], 2'b00};
    assign mem_write_data = data_q;
    // Reset kills the strobe immediately so a half-done store never lands.
    assign mem_write      = (state == WRITE) & ~reset;

    // Request sequencing, word capture/merge and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= 32'b0;
            data_q     <= 32'b0;
            op_q       <= 3'b0;
            store_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= 32'b0;
            resp_error <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_address;
                        data_q    <= req_wdata;
                        op_q      <= req_op;
                        store_q   <= req_store;
                        resp_data <= 32'b0;
                        if (req_error) begin
                            resp_error <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            resp_error <= 1'b0;
                            state      <= store_word ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    if (store_q) begin
                        data_q <= store_merge(mem_read_data, data_q,
                                              op_q[0], addr_q[1:0]);
                        state  <= WRITE;
                    end else begin
                        resp_data  <= load_extract(mem_read_data, op_q,
                                                   addr_q[1:0]);
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store traffic against a
// byte-array memory model; the bench also plays the data_memory role.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_op;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_write;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;

    logic [31:0] mem [0:255];
    logic [7:0]  ref_mem [0:1023];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_op         (req_op),
        .req_address    (req_address),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_write      (mem_write)
    );

    assign mem_read_data = (mem_address < 32'd1024) ? mem[mem_address[9:2]] : 32'h0;

    always @(negedge clk) begin
        if (mem_write) begin
            if (mem_address < 32'd1024) mem[mem_address[9:2]] <= mem_write_data;
            n_writes <= n_writes + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference: byte-addressed memory, big-endian composition of wider accesses.
    task automatic model_req(input bit st, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] d,
                             output bit e, output int lat);
        int sz;
        longint v;
        sz = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        e = (op == 3'b010) || (op == 3'b110) || (op == 3'b111) || (st && op[2])
            || (a % sz != 0) || (a > 32'd1020);
        d = 32'h0;
        if (e) begin
            lat = 1;
        end else if (st) begin
            for (int i = 0; i < sz; i++)
                ref_mem[a + i] = 8'(wd >> (8 * (sz - 1 - i)));
            lat = (sz == 4) ? 2 : 3;
        end else begin
            v = 0;
            for (int i = 0; i < sz; i++) v = (v << 8) | longint'(ref_mem[a + i]);
            if (!op[2] && v[8 * sz - 1]) v = v - (64'sd1 <<< (8 * sz));
            d = v[31:0];
            lat = 2;
        end
    endtask

    // One transaction: drive, count cycles from the accept cycle, compare to model.
    task automatic do_req(input bit st, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input string tag,
                          output logic [31:0] data, output logic err);
        logic [31:0] ed;
        bit ee;
        int elat, lat, w0, n;
        bit got;
        model_req(st, op, a, wd, ed, ee, elat);
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_op = op;
        req_address = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        w0 = n_writes;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 0; lat = 0; data = 'x; err = 1'bx;
        for (int i = 1; i <= 8 && !got; i++) begin
            if (resp_valid) begin
                got = 1; lat = i; data = resp_data; err = resp_error;
            end else begin
                @(posedge clk); #1;
            end
        end
        check({tag, "_resp"}, {31'b0, got}, 32'd1);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_err"}, {31'b0, err}, {31'b0, ee});
        check({tag, "_data"}, data, ed);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_nwr"}, n_writes - w0, (st && !ee) ? 1 : 0);
    endtask

    logic [31:0] d;
    logic        e;
    logic [2:0]  ops [8];
    int          w0;
    logic [31:0] r;

    initial begin
        ops = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b010, 3'b110, 3'b111};
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_op = 3'b0;
        req_address = 32'h0; req_wdata = 32'h0;
        for (int w = 0; w < 256; w++) begin
            r = $urandom;
            mem[w] <= r;
            for (int b = 0; b < 4; b++) ref_mem[4 * w + b] = 8'(r >> (24 - 8 * b));
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_err", {31'b0, resp_error}, 32'd0);
        check("rst_mwr", {31'b0, mem_write}, 32'd0);
        check("rst_maddr", mem_address, 32'd0);
        check("rst_mwdata", mem_write_data, 32'd0);
        reset = 1'b0;

        do_req(1, 3'b011, 32'h10, 32'h11223344, "t1_sw", d, e);
        do_req(0, 3'b011, 32'h10, 32'h0, "t1_lw", d, e);
        check("t1_lit", d, 32'h11223344);

        do_req(1, 3'b000, 32'h12, 32'h000000AA, "t2_sb", d, e);
        do_req(0, 3'b011, 32'h10, 32'h0, "t2_lw", d, e);
        check("t2_lit_lw", d, 32'h1122AA44);
        do_req(0, 3'b000, 32'h12, 32'h0, "t2_lb", d, e);
        check("t2_lit_lb", d, 32'hFFFFFFAA);
        do_req(0, 3'b100, 32'h12, 32'h0, "t2_lbu", d, e);
        check("t2_lit_lbu", d, 32'h000000AA);

        do_req(1, 3'b001, 32'h12, 32'h00008001, "t3_sh", d, e);
        do_req(0, 3'b011, 32'h10, 32'h0, "t3_lw", d, e);
        check("t3_lit_lw", d, 32'h11228001);
        do_req(0, 3'b001, 32'h12, 32'h0, "t3_lh", d, e);
        check("t3_lit_lh", d, 32'hFFFF8001);
        do_req(0, 3'b101, 32'h12, 32'h0, "t3_lhu", d, e);
        check("t3_lit_lhu", d, 32'h00008001);
        do_req(0, 3'b001, 32'h10, 32'h0, "t3_lh0", d, e);
        check("t3_lit_lh0", d, 32'h00001122);

        do_req(0, 3'b011, 32'h12, 32'h0, "t4_lwmis", d, e);
        do_req(1, 3'b001, 32'h11, 32'hFFFF, "t4_shmis", d, e);
        do_req(0, 3'b010, 32'h10, 32'h0, "t4_ill", d, e);
        do_req(1, 3'b100, 32'h10, 32'h0, "t4_illst", d, e);
        do_req(0, 3'b011, 32'h10, 32'h0, "t4_lw", d, e);
        check("t4_lit_lw", d, 32'h11228001);

        do_req(1, 3'b011, 32'h3FC, 32'hDEADBEEF, "t5_sw", d, e);
        do_req(0, 3'b011, 32'h3FC, 32'h0, "t5_lw", d, e);
        check("t5_lit_lw", d, 32'hDEADBEEF);
        do_req(0, 3'b011, 32'h400, 32'h0, "t5_oor", d, e);
        check("t5_lit_err", {31'b0, e}, 32'd1);

        // Reset lands in the WRITE cycle of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_op = 3'b000;
        req_address = 32'h13; req_wdata = 32'h55;
        check("t6_ready", {31'b0, req_ready}, 32'd1);
        w0 = n_writes;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("t6_v1", {31'b0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("t6_inwrite", {31'b0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6_mwr_rst", {31'b0, mem_write}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_v2", {31'b0, resp_valid}, 32'd0);
        check("t6_ready_after", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("t6_v3", {31'b0, resp_valid}, 32'd0);
        check("t6_nwr", n_writes - w0, 32'd0);
        do_req(0, 3'b011, 32'h10, 32'h0, "t6_lw", d, e);
        check("t6_lit_lw", d, 32'h11228001);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 63))
                                            : 32'($urandom_range(1012, 1031));
            do_req($urandom_range(0, 1) == 1, ops[$urandom_range(0, 7)], a,
                   $urandom, "rnd", d, e);
        end

        for (int w = 0; w < 256; w++)
            check("mem_final", mem[w], {ref_mem[4 * w], ref_mem[4 * w + 1],
                                        ref_mem[4 * w + 2], ref_mem[4 * w + 3]});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
